// File: rtl/tdm_demux.sv
// Time-division demultiplexer: collects N_CH serialized lane words into a shadow
// buffer and publishes the complete frame to DOUT in a single step.
module tdm_demux #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    localparam int SW  = $clog2(N_CH)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [W-1:0]        DIN,
    input  logic                DIN_VLD,
    input  logic                DIN_SOF,
    output logic [N_CH*W-1:0]   DOUT,
    output logic                DOUT_VLD,
    output logic [SW-1:0]       SLOT,
    output logic                BUSY,
    output logic                ERR
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    localparam logic [SW-1:0] SLOT_ZERO = SW'(0);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(N_CH - 1);

    logic [0:0]             state_q, state_d;
    logic [SW-1:0]          slot_q, slot_d;
    logic [N_CH-1:0][W-1:0] shadow_q, shadow_d;
    logic [N_CH*W-1:0]      dout_q, dout_d;
    logic                   dout_vld_q, dout_vld_d;
    logic                   err_q, err_d;

    // Next-state logic: frame assembly, completion transfer and protocol errors
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        shadow_d   = shadow_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (DIN_VLD && DIN_SOF) begin
                    shadow_d[0] = DIN;
                    slot_d      = SLOT_ONE;
                    state_d     = S_FILL;
                end else if (DIN_VLD) begin
                    err_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (DIN_VLD && DIN_SOF) begin
                    // Premature SOF restarts the frame; DOUT keeps the last good frame
                    err_d       = 1'b1;
                    shadow_d[0] = DIN;
                    slot_d      = SLOT_ONE;
                end else if (DIN_VLD && (slot_q == SLOT_LAST)) begin
                    dout_d     = {DIN, shadow_q[N_CH-2:0]};
                    dout_vld_d = 1'b1;
                    slot_d     = SLOT_ZERO;
                    state_d    = S_IDLE;
                end else if (DIN_VLD) begin
                    shadow_d[slot_q] = DIN;
                    slot_d           = slot_q + SLOT_ONE;
                end else begin
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_IDLE;
                slot_d  = SLOT_ZERO;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            slot_q     <= SLOT_ZERO;
            shadow_q   <= '{default: {W{1'b0}}};
            dout_q     <= {(N_CH*W){1'b0}};
            dout_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            shadow_q   <= shadow_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            err_q      <= err_d;
        end
    end

    assign DOUT     = dout_q;
    assign DOUT_VLD = dout_vld_q;
    assign SLOT     = slot_q;
    assign BUSY     = (state_q == S_FILL);
    assign ERR      = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: hand-computed vector table plus random traffic, three
// parameterisations driven in parallel and checked against a frame-level model.
module tb_tdm_demux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic        sof = 1'b0;
    logic [15:0] din = 16'h0000;

    logic [31:0] dout_n4, dout_n2, dout_n8;
    logic        dv_n4, dv_n2, dv_n8;
    logic        err_n4, err_n2, err_n8;
    logic        busy_n4, busy_n2, busy_n8;
    logic [1:0]  slot_n4;
    logic [0:0]  slot_n2;
    logic [2:0]  slot_n8;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tdm_demux #(.N_CH(4), .W(8)) u_n4 (
        .CLK(clk), .RST(rst), .DIN(din[7:0]), .DIN_VLD(vld), .DIN_SOF(sof),
        .DOUT(dout_n4), .DOUT_VLD(dv_n4), .SLOT(slot_n4), .BUSY(busy_n4), .ERR(err_n4));
    tdm_demux #(.N_CH(2), .W(16)) u_n2 (
        .CLK(clk), .RST(rst), .DIN(din[15:0]), .DIN_VLD(vld), .DIN_SOF(sof),
        .DOUT(dout_n2), .DOUT_VLD(dv_n2), .SLOT(slot_n2), .BUSY(busy_n2), .ERR(err_n2));
    tdm_demux #(.N_CH(8), .W(4)) u_n8 (
        .CLK(clk), .RST(rst), .DIN(din[3:0]), .DIN_VLD(vld), .DIN_SOF(sof),
        .DOUT(dout_n8), .DOUT_VLD(dv_n8), .SLOT(slot_n8), .BUSY(busy_n8), .ERR(err_n8));

    // Frame-level reference: a list of collected words per configuration
    int          cfg_n [3] = '{4, 2, 8};
    int          cfg_w [3] = '{8, 16, 4};
    logic [15:0] words [3][8];
    int          cnt   [3];
    bit          in_frame [3];
    logic [31:0] m_dout [3];
    bit          m_vld [3];
    bit          m_err [3];

    task automatic model_step(input bit r, input bit v, input bit s, input logic [15:0] d);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] dm;
            logic [31:0] acc;
            dm = d & 16'((32'd1 << cfg_w[i]) - 32'd1);
            m_vld[i] = 1'b0;
            m_err[i] = 1'b0;
            if (r) begin
                in_frame[i] = 1'b0;
                cnt[i]      = 0;
                m_dout[i]   = 32'h0;
            end else if (v && s) begin
                m_err[i]    = in_frame[i];
                words[i][0] = dm;
                cnt[i]      = 1;
                in_frame[i] = 1'b1;
            end else if (v && !in_frame[i]) begin
                m_err[i] = 1'b1;
            end else if (v) begin
                words[i][cnt[i]] = dm;
                cnt[i]           = cnt[i] + 1;
                if (cnt[i] == cfg_n[i]) begin
                    acc = 32'h0;
                    for (int k = 0; k < cfg_n[i]; k++)
                        acc = acc | (32'(words[i][k]) << (k * cfg_w[i]));
                    m_dout[i]   = acc;
                    m_vld[i]    = 1'b1;
                    in_frame[i] = 1'b0;
                    cnt[i]      = 0;
                end
            end
        end
    endtask

    task automatic check_inst(input int i, input string tag, input logic [31:0] d,
                              input logic dv, input logic e, input int sl, input logic b);
        int exp_slot;
        exp_slot = in_frame[i] ? cnt[i] : 0;
        n_vec++;
        if (d !== m_dout[i] || dv !== m_vld[i] || e !== m_err[i] ||
            sl != exp_slot || b !== logic'(in_frame[i])) begin
            n_fail++;
            $display("FAIL %s n_ch=%0d: got dout=%h vld=%b err=%b slot=%0d busy=%b, want dout=%h vld=%b err=%b slot=%0d busy=%b",
                     tag, cfg_n[i], d, dv, e, sl, b, m_dout[i], m_vld[i], m_err[i], exp_slot, in_frame[i]);
        end
    endtask

    task automatic check_model(input string tag);
        check_inst(0, tag, dout_n4, dv_n4, err_n4, int'(slot_n4), busy_n4);
        check_inst(1, tag, dout_n2, dv_n2, err_n2, int'(slot_n2), busy_n2);
        check_inst(2, tag, dout_n8, dv_n8, err_n8, int'(slot_n8), busy_n8);
    endtask

    task automatic drive(input bit r, input bit v, input bit s, input logic [15:0] d);
        @(negedge clk);
        rst = r; vld = v; sof = s; din = d;
        @(posedge clk);
        model_step(r, v, s, d);
        #1;
    endtask

    typedef struct {
        bit          rst, vld, sof;
        logic [15:0] din;
        bit          e_vld, e_err, e_busy;
        int          e_slot;
        logic [31:0] e_dout;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input bit r, input bit v, input bit s, input logic [15:0] d,
                       input bit ev, input bit ee, input bit eb, input int es, input logic [31:0] ed);
        vec_t t;
        t.name = nm; t.rst = r; t.vld = v; t.sof = s; t.din = d;
        t.e_vld = ev; t.e_err = ee; t.e_busy = eb; t.e_slot = es; t.e_dout = ed;
        tbl.push_back(t);
    endtask

    initial begin
        // Expected columns are for the N_CH=4, W=8 instance
        add("reset",      1, 1, 1, 16'h0099, 0, 0, 0, 0, 32'h0);
        add("basic0",     0, 1, 1, 16'h0011, 0, 0, 1, 1, 32'h0);
        add("basic1",     0, 1, 0, 16'h0022, 0, 0, 1, 2, 32'h0);
        add("basic2",     0, 1, 0, 16'h0033, 0, 0, 1, 3, 32'h0);
        add("basic3",     0, 1, 0, 16'h0044, 1, 0, 0, 0, 32'h44332211);
        add("gapA0",      0, 1, 1, 16'h00A0, 0, 0, 1, 1, 32'h44332211);
        add("gap",        0, 0, 0, 16'h00EE, 0, 0, 1, 1, 32'h44332211);
        add("gapA1",      0, 1, 0, 16'h00A1, 0, 0, 1, 2, 32'h44332211);
        add("gap_sof",    0, 0, 1, 16'h00EE, 0, 0, 1, 2, 32'h44332211);
        add("gapA2",      0, 1, 0, 16'h00A2, 0, 0, 1, 3, 32'h44332211);
        add("gap",        0, 0, 0, 16'h00EE, 0, 0, 1, 3, 32'h44332211);
        add("gapA3",      0, 1, 0, 16'h00A3, 1, 0, 0, 0, 32'hA3A2A1A0);
        add("b2bB0",      0, 1, 1, 16'h00B0, 0, 0, 1, 1, 32'hA3A2A1A0);
        add("b2bB1",      0, 1, 0, 16'h00B1, 0, 0, 1, 2, 32'hA3A2A1A0);
        add("b2bB2",      0, 1, 0, 16'h00B2, 0, 0, 1, 3, 32'hA3A2A1A0);
        add("b2bB3",      0, 1, 0, 16'h00B3, 1, 0, 0, 0, 32'hB3B2B1B0);
        add("pre01",      0, 1, 1, 16'h0001, 0, 0, 1, 1, 32'hB3B2B1B0);
        add("pre02",      0, 1, 0, 16'h0002, 0, 0, 1, 2, 32'hB3B2B1B0);
        add("pre_sof10",  0, 1, 1, 16'h0010, 0, 1, 1, 1, 32'hB3B2B1B0);
        add("pre20",      0, 1, 0, 16'h0020, 0, 0, 1, 2, 32'hB3B2B1B0);
        add("pre30",      0, 1, 0, 16'h0030, 0, 0, 1, 3, 32'hB3B2B1B0);
        add("pre40",      0, 1, 0, 16'h0040, 1, 0, 0, 0, 32'h40302010);
        add("stray55",    0, 1, 0, 16'h0055, 0, 1, 0, 0, 32'h40302010);
        add("after61",    0, 1, 1, 16'h0061, 0, 0, 1, 1, 32'h40302010);
        add("after62",    0, 1, 0, 16'h0062, 0, 0, 1, 2, 32'h40302010);
        add("after63",    0, 1, 0, 16'h0063, 0, 0, 1, 3, 32'h40302010);
        add("after64",    0, 1, 0, 16'h0064, 1, 0, 0, 0, 32'h64636261);
        add("mid01",      0, 1, 1, 16'h0001, 0, 0, 1, 1, 32'h64636261);
        add("mid02",      0, 1, 0, 16'h0002, 0, 0, 1, 2, 32'h64636261);
        add("mid_rst",    1, 0, 0, 16'h0000, 0, 0, 0, 0, 32'h0);
        add("mid0A",      0, 1, 1, 16'h000A, 0, 0, 1, 1, 32'h0);
        add("mid0B",      0, 1, 0, 16'h000B, 0, 0, 1, 2, 32'h0);
        add("mid0C",      0, 1, 0, 16'h000C, 0, 0, 1, 3, 32'h0);
        add("mid0D",      0, 1, 0, 16'h000D, 1, 0, 0, 0, 32'h0D0C0B0A);
        add("hold",       0, 0, 0, 16'h00FF, 0, 0, 0, 0, 32'h0D0C0B0A);

        for (int v = 0; v < tbl.size(); v++) begin
            drive(tbl[v].rst, tbl[v].vld, tbl[v].sof, tbl[v].din);
            n_vec++;
            if (dout_n4 !== tbl[v].e_dout || dv_n4 !== tbl[v].e_vld || err_n4 !== tbl[v].e_err ||
                busy_n4 !== tbl[v].e_busy || int'(slot_n4) != tbl[v].e_slot) begin
                n_fail++;
                $display("FAIL tbl[%0d] %s: got dout=%h vld=%b err=%b busy=%b slot=%0d, want dout=%h vld=%b err=%b busy=%b slot=%0d",
                         v, tbl[v].name, dout_n4, dv_n4, err_n4, busy_n4, slot_n4,
                         tbl[v].e_dout, tbl[v].e_vld, tbl[v].e_err, tbl[v].e_busy, tbl[v].e_slot);
            end
            check_model(tbl[v].name);
        end

        // Randomized traffic with occasional resets, premature SOFs and stray words
        for (int c = 0; c < 600; c++) begin
            bit          r, v, s;
            logic [15:0] d;
            r = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 5) == 0);
            d = 16'($urandom);
            drive(r, v, s, d);
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer that receives one serialized lane stream on a shared line and distributes the words to N_CH parallel output lanes.
- Upstream, mux trees built from 2:1 cells serialize the lanes; this block rebuilds the parallel frame on the neuron-array side.
- Words are captured into a shadow buffer. A completed frame is transferred to the output registers in one step, so downstream logic never sees a partial frame.

Parameters:
N_CH, 4, number of output lanes (slots per frame), must be >= 2
W, 8, data width of each lane word
SW, $clog2(N_CH), slot index width (derived, not overridden)

Ports:
CLK  input  1  single clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high
DIN  input  W  serialized lane word
DIN_VLD  input  1  DIN carries a valid word this cycle
DIN_SOF  input  1  start of frame; qualified only when DIN_VLD=1; marks slot 0
DOUT  output  N_CH*W  parallel frame; lane k is bits [k*W +: W]
DOUT_VLD  output  1  one-cycle pulse: DOUT has just been updated with a new frame
SLOT  output  SW  index of the next expected slot (slot counter)
BUSY  output  1  1 while in FILL state
ERR  output  1  one-cycle pulse on frame protocol error

Behaviour:
- Reset: while RST=1 at a clock edge, the block clears the following:
  - DOUT=0, shadow buffer=0
  - DOUT_VLD=0, ERR=0, SLOT=0, BUSY=0
  - state=IDLE
  - RST overrides every other input in that cycle, including a mid-frame reset; the partial frame is discarded.
- State machine: two states, IDLE and FILL.
- IDLE:
  - DIN_VLD=1, DIN_SOF=1: write shadow[0]=DIN, SLOT<=1, go to FILL.
  - DIN_VLD=1, DIN_SOF=0: word is dropped, ERR pulses, remain in IDLE.
  - DIN_VLD=0: hold.
- FILL:
  - DIN_VLD=0: hold (gaps between words are allowed, with no timeout).
  - DIN_VLD=1, DIN_SOF=0, SLOT<N_CH-1: write shadow[SLOT]=DIN, SLOT<=SLOT+1.
  - DIN_VLD=1, DIN_SOF=0, SLOT=N_CH-1: write the last word. On the same edge:
    - DOUT<={DIN, shadow[N_CH-2:0]}
    - DOUT_VLD<=1 for one cycle
    - SLOT<=0, go to IDLE
  - DIN_VLD=1, DIN_SOF=1 (premature SOF, any SLOT in FILL): ERR pulses and the partial frame is abandoned. The new word becomes slot 0: shadow[0]=DIN, SLOT<=1, stay in FILL. DOUT is unchanged.
- Latency: DOUT and DOUT_VLD update on the same edge that samples the last word, i.e. they are visible 1 cycle after that word is presented.
- Back-to-back frames: an SOF in the cycle right after the completing word is accepted normally from IDLE, giving no bubble and 100% throughput.
- DOUT holds its last complete frame until the next frame completes. Error or abandoned frames never modify DOUT.
- DIN_SOF with DIN_VLD=0 is ignored in all states.
- BUSY=1 exactly when state=FILL. SLOT reports the registered counter value.
- ERR and DOUT_VLD are registered pulses and can never be 1 in the same cycle.
- Shadow-register contents for slots not yet rewritten are don't-care. They never reach DOUT, because every slot is rewritten before a transfer.

Test Plan:
- Basic frame: reset, then 4 consecutive VLD words 0x11 (SOF), 0x22, 0x33, 0x44 -> DOUT_VLD pulses once, one cycle after 0x44; DOUT=0x44332211; SLOT sequence 1,2,3,0.
- Gapped + back-to-back: frame A (0xA0..0xA3) with idle cycles between words, then frame B (0xB0..0xB3, SOF on 0xB0) immediately after -> two DOUT_VLD pulses; DOUT=0xA3A2A1A0 then 0xB3B2B1B0; DOUT stable between pulses.
- Premature SOF: SOF 0x01, 0x02, then SOF 0x10, 0x20, 0x30, 0x40 -> ERR pulses once, at the second SOF; single DOUT_VLD with DOUT=0x40302010; DOUT unchanged before that.
- Stray word in IDLE: after reset, VLD 0x55 with SOF=0 -> ERR pulse, SLOT=0, BUSY=0. A following valid frame is captured correctly.
- Mid-frame reset: SOF 0x01, 0x02, assert RST for 1 cycle, then full frame 0x0A..0x0D -> after reset DOUT=0, SLOT=0; then DOUT=0x0D0C0B0A with exactly one DOUT_VLD and no ERR.
- Parameter sweep: N_CH=2, W=16 and N_CH=8, W=4 -> the basic-frame and premature-SOF checks pass, with SLOT wrapping at N_CH-1.
